// File: rtl/apb_pkg.sv
// Shared types for the APB master: bus address/data widths and the transfer FSM states.
package apb_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_master_if.sv
// Bundles the command/response handshake and the APB completer bus of the APB master.
// The master modport is the view of the bridge itself; slave is the view of whoever
// issues commands and plays the completer.
interface apb_master_if;
  import apb_pkg::*;

  logic  cmd_valid;
  logic  cmd_ready;
  addr_t cmd_addr;
  logic  cmd_write;
  data_t cmd_wdata;

  logic  rsp_valid;
  logic  rsp_ready;
  data_t rsp_rdata;
  logic  rsp_err;
  logic  rsp_timeout;

  logic  PSEL;
  logic  PENABLE;
  addr_t PADDR;
  logic  PWRITE;
  data_t PWDATA;
  logic  PREADY;
  data_t PRDATA;
  logic  PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
    input  PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
    output PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_master.sv
// APB master: turns one command at a time into an APB SETUP/ACCESS transfer and returns
// a single response. Every bus and response output comes straight from a register.
// A transfer whose completer never raises PREADY is aborted after TIMEOUT_CYCLES
// ACCESS cycles and reported as an error with rsp_timeout set.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  apb_master_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  apb_state_t       state_q,      state_d;
  logic             psel_q,       psel_d;
  logic             penable_q,    penable_d;
  addr_t            paddr_q,      paddr_d;
  logic             pwrite_q,     pwrite_d;
  data_t            pwdata_q,     pwdata_d;
  logic             rspValid_q,   rspValid_d;
  data_t            rspRdata_q,   rspRdata_d;
  logic             rspErr_q,     rspErr_d;
  logic             rspTimeout_q, rspTimeout_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] cntNext;
  logic             cmdReady;

  // A new command is only taken while idle with no response still waiting to be consumed.
  assign cmdReady = (state_q == IDLE) && !rspValid_q;
  assign cntNext  = cnt_q + 1'b1;

  assign bus.cmd_ready   = cmdReady;
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_rdata   = rspRdata_q;
  assign bus.rsp_err     = rspErr_q;
  assign bus.rsp_timeout = rspTimeout_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;

  // State and output registers; reset drops any transfer in flight without a response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      rspValid_q   <= rspValid_d;
      rspRdata_q   <= rspRdata_d;
      rspErr_q     <= rspErr_d;
      rspTimeout_q <= rspTimeout_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, one SETUP cycle, then ACCESS until PREADY or timeout.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    rspValid_d   = rspValid_q;
    rspRdata_d   = rspRdata_q;
    rspErr_d     = rspErr_q;
    rspTimeout_d = rspTimeout_q;
    cnt_d        = cnt_q;

    if (rspValid_q && bus.rsp_ready) begin
      rspValid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmdReady) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          cnt_d     = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          state_d      = IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          pwdata_d     = '0;
          rspValid_d   = 1'b1;
          rspRdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rspErr_d     = bus.PSLVERR;
          rspTimeout_d = 1'b0;
        end else begin
          cnt_d = cntNext;
          if (cntNext == CNT_LIMIT) begin
            state_d      = IDLE;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            pwdata_d     = '0;
            rspValid_d   = 1'b1;
            rspRdata_d   = '0;
            rspErr_d     = 1'b1;
            rspTimeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a directed table, randomized transfers scored
// against a transaction-level model, and a reset-during-ACCESS sequence.
module tb_apb_master;
  import apb_pkg::*;

  localparam int T = 16;

  logic PCLK = 1'b0;
  logic PRESETn;

  apb_master_if bus();

  apb_master #(.TIMEOUT_CYCLES(T)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    int          rspDelay;
    logic [31:0] expRdata;
    logic        expErr;
    logic        expTo;
  } vec_t;

  vec_t dirTab[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  function automatic vec_t mkVec(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                                 input int waits, input logic slverr, input logic [31:0] prdata,
                                 input int rspDelay, input logic [31:0] expRdata,
                                 input logic expErr, input logic expTo);
    vec_t v;
    v.addr = addr; v.write = write; v.wdata = wdata; v.waits = waits;
    v.slverr = slverr; v.prdata = prdata; v.rspDelay = rspDelay;
    v.expRdata = expRdata; v.expErr = expErr; v.expTo = expTo;
    return v;
  endfunction

  // Transaction-level model: a completer that stays silent for T or more ACCESS cycles
  // causes a timeout, otherwise the response reflects what it returned.
  function automatic vec_t refModel(input vec_t v);
    vec_t r = v;
    if (v.waits >= T) begin
      r.expRdata = '0; r.expErr = 1'b1; r.expTo = 1'b1;
    end else begin
      r.expRdata = v.write ? 32'h0 : v.prdata;
      r.expErr   = v.slverr;
      r.expTo    = 1'b0;
    end
    return r;
  endfunction

  // Runs one full command: accept, SETUP, ACCESS with wait states, response, backpressure.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] expPwdata;
    int          acc;
    expPwdata = v.write ? v.wdata : 32'h0;
    acc       = (v.waits < T) ? v.waits + 1 : T;

    checkBit("cmd_ready before accept", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_write = v.write;
    bus.cmd_wdata = v.wdata;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_wdata = $urandom;

    checkOutput("SETUP psel/penable/rsp_valid", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 32'h4);
    checkOutput("SETUP PADDR", bus.PADDR, v.addr);
    checkBit("SETUP PWRITE", bus.PWRITE, v.write);
    checkOutput("SETUP PWDATA", bus.PWDATA, expPwdata);
    checkBit("SETUP cmd_ready", bus.cmd_ready, 1'b0);
    bus.PREADY  = 1'($urandom_range(0, 1));
    bus.PRDATA  = $urandom;
    bus.PSLVERR = 1'($urandom_range(0, 1));
    tick();

    for (int k = 0; k < acc; k++) begin
      checkOutput("ACCESS psel/penable/rsp_valid", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 32'h6);
      checkOutput("ACCESS PADDR", bus.PADDR, v.addr);
      checkOutput("ACCESS PWDATA", bus.PWDATA, expPwdata);
      bus.PREADY  = (k == v.waits);
      bus.PRDATA  = (k == v.waits) ? v.prdata : $urandom;
      bus.PSLVERR = (k == v.waits) ? v.slverr : 1'($urandom_range(0, 1));
      tick();
    end
    bus.PREADY  = 1'($urandom_range(0, 1));
    bus.PRDATA  = $urandom;
    bus.PSLVERR = 1'($urandom_range(0, 1));

    checkOutput("done psel/penable/rsp_valid", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 32'h1);
    checkOutput("rsp_rdata", bus.rsp_rdata, v.expRdata);
    checkBit("rsp_err", bus.rsp_err, v.expErr);
    checkBit("rsp_timeout", bus.rsp_timeout, v.expTo);
    checkOutput("IDLE PWDATA", bus.PWDATA, 32'h0);
    checkOutput("IDLE PADDR kept", bus.PADDR, v.addr);
    checkBit("IDLE PWRITE kept", bus.PWRITE, v.write);
    checkBit("cmd_ready with rsp pending", bus.cmd_ready, 1'b0);

    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int d = 0; d < v.rspDelay; d++) begin
      tick();
      checkOutput("held rsp_valid/psel", 32'({bus.rsp_valid, bus.PSEL}), 32'h2);
      checkOutput("held rsp_rdata", bus.rsp_rdata, v.expRdata);
      checkOutput("held err/timeout", 32'({bus.rsp_err, bus.rsp_timeout}), 32'({v.expErr, v.expTo}));
      checkBit("held cmd_ready", bus.cmd_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    checkBit("rsp_valid cleared", bus.rsp_valid, 1'b0);
    checkBit("no accept while rsp_valid", bus.PSEL, 1'b0);
    checkBit("cmd_ready after consume", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    dirTab[0] = mkVec(32'h10,  1'b1, 32'hDEADBEEF, 0,   1'b0, 32'hCAFEF00D, 0, 32'h0,        1'b0, 1'b0);
    dirTab[1] = mkVec(32'h10,  1'b0, 32'h0,        3,   1'b0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0, 1'b0);
    dirTab[2] = mkVec(32'h400, 1'b0, 32'h0,        0,   1'b1, 32'h12345678, 0, 32'h12345678, 1'b1, 1'b0);
    dirTab[3] = mkVec(32'h20,  1'b0, 32'h0,        100, 1'b0, 32'h55555555, 0, 32'h0,        1'b1, 1'b1);
    dirTab[4] = mkVec(32'h24,  1'b0, 32'h0,        15,  1'b0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1'b0, 1'b0);
    dirTab[5] = mkVec(32'h30,  1'b1, 32'h00000011, 2,   1'b0, 32'h77777777, 5, 32'h0,        1'b0, 1'b0);
    dirTab[6] = mkVec(32'h34,  1'b1, 32'h87654321, 16,  1'b0, 32'h0,        0, 32'h0,        1'b1, 1'b1);
    dirTab[7] = mkVec(32'h38,  1'b1, 32'h0BADF00D, 1,   1'b1, 32'hFFFFFFFF, 2, 32'h0,        1'b1, 1'b0);

    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;
    #1;
    checkOutput("reset psel/penable/rsp_valid", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 32'h0);
    checkOutput("reset PADDR", bus.PADDR, 32'h0);
    checkOutput("reset PWDATA", bus.PWDATA, 32'h0);
    checkOutput("reset rsp fields", 32'({bus.PWRITE, bus.rsp_err, bus.rsp_timeout}), 32'h0);
    checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    tick();
    tick();
    PRESETn = 1'b1;
    tick();
    checkBit("cmd_ready after reset", bus.cmd_ready, 1'b1);

    $display("[TB] directed table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(dirTab[i]);
    end

    $display("[TB] reset during ACCESS");
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h44;
    bus.cmd_write = 1'b1;
    bus.cmd_wdata = 32'h12121212;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    checkOutput("pre-reset ACCESS", 32'({bus.PSEL, bus.PENABLE}), 32'h3);
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("mid reset psel/penable/rsp_valid", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 32'h0);
    checkOutput("mid reset PADDR", bus.PADDR, 32'h0);
    bus.PREADY = 1'b1;
    tick();
    PRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("post reset quiet", 32'({bus.PSEL, bus.rsp_valid, bus.cmd_ready}), 32'h1);
    end
    bus.PREADY = 1'b0;
    applyStimulus(dirTab[1]);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 24; i++) begin
      v.addr     = $urandom;
      v.write    = 1'($urandom_range(0, 1));
      v.wdata    = $urandom;
      v.waits    = $urandom_range(0, 20);
      v.slverr   = 1'($urandom_range(0, 1));
      v.prdata   = $urandom;
      v.rspDelay = $urandom_range(0, 3);
      applyStimulus(refModel(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
